// File: rtl/ctrl_dly_fifo_if.sv
// ----------------------------------------------------------------------------
// ctrl_dly_fifo_if
// Bundles the write strobe, the valid/ready read side and the status outputs
// of ctrl_dly_fifo.
//   slave  : the FIFO itself (takes in_vld/din/out_rdy; drives the rest)
//   master : the environment around it (upstream pipe + consumer)
// Signals:
//   in_vld, din          write strobe and data from the delay pipe (no ready)
//   out_vld, dout        head entry valid and data
//   out_rdy              consumer accepts the head entry
//   afull                free entries <= AFULL_TH, upstream must stop issuing
//   count                occupancy 0..DEPTH
//   ovf                  sticky overflow flag (0 unless CTRL_DLY_FIFO_OVF_EN)
// ----------------------------------------------------------------------------
interface ctrl_dly_fifo_if #(
  parameter int DWID  = 10,
  parameter int DEPTH = 8
);
  logic                     in_vld;
  logic [DWID-1:0]          din;
  logic                     out_vld;
  logic [DWID-1:0]          dout;
  logic                     out_rdy;
  logic                     afull;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovf;

  modport slave (
    input  in_vld, din, out_rdy,
    output out_vld, dout, afull, count, ovf
  );

  modport master (
    output in_vld, din, out_rdy,
    input  out_vld, dout, afull, count, ovf
  );
endinterface

// File: rtl/ctrl_dly_fifo.sv
// ----------------------------------------------------------------------------
// ctrl_dly_fifo
// Elastic buffer behind a fixed-latency delay pipe. Words arriving on in_vld
// are written unconditionally (there is no in-ready); the consumer side is a
// plain valid/ready interface. afull warns the upstream source early enough
// that words already in flight still fit.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears pointers, count, ovf and all
//          storage (dout reads 0 after reset)
//   bus    ctrl_dly_fifo_if.slave (in_vld, din, out_vld, dout, out_rdy,
//          afull, count, ovf)
// Optional feature: define CTRL_DLY_FIFO_OVF_EN to build the sticky overflow
// flag and a 16-bit saturating drop counter (drop_cnt_q, debug visibility
// only). Without it ovf is tied 0 and drops are silent.
// All outputs derive from registers only.
// ----------------------------------------------------------------------------
module ctrl_dly_fifo #(
  parameter int DWID     = 10,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ctrl_dly_fifo_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // afull when DEPTH - count <= AFULL_TH, i.e. count >= DEPTH - AFULL_TH.
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_TH);
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_TH < 0 || AFULL_TH >= DEPTH)
  begin : g_bad_cfg
    $error("ctrl_dly_fifo: illegal DEPTH/AFULL_TH combination");
  end

  logic [DWID-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            full;
  logic            pop;
  logic            push;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full     = (count_q == FULL_LVL);
    pop      = (count_q != '0) && bus.out_rdy;
    // A full FIFO still accepts a write when the head leaves the same cycle.
    push     = bus.in_vld && (!full || pop);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately reset so dout reads a defined 0 after reset
  // instead of stale or X data; it therefore cannot map onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  assign bus.out_vld = (count_q != '0);
  assign bus.dout    = mem_q[rd_ptr_q];
  assign bus.count   = count_q;
  assign bus.afull   = (count_q >= AFULL_LVL);

`ifdef CTRL_DLY_FIFO_OVF_EN
  logic        drop;
  logic        ovf_q;
  logic [15:0] drop_cnt_q;

  // A word is lost only when full with no pop to make room.
  assign drop = bus.in_vld && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: doc/ctrl_dly_fifo.md
# ctrl_dly_fifo

Elastic buffer that sits directly downstream of fixed-latency `ctrl_dly` pipelines and gives a non-stallable delay line a valid/ready output. Data leaving a delay pipe is written unconditionally. The FIFO absorbs words that are already in flight when the consumer deasserts ready. A threshold-based almost-full signal tells the upstream source to stop issuing early enough that the pipe drains without loss.

## Interface
Parameters:
- `DWID`, 10, data width in bits.
- `DEPTH`, 8, number of storage entries; power of two, ≥ 2.
- `AFULL_TH`, 1, free-entry margin. Set it to at least the upstream delay depth. Constraint: 0 ≤ `AFULL_TH` < `DEPTH`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_vld`  in  1  write strobe from the upstream delay pipe; there is no in-ready.
- `din`  in  `DWID`  write data.
- `out_vld`  out  1  head entry is valid.
- `dout`  out  `DWID`  head entry data.
- `out_rdy`  in  1  consumer accepts the head entry this cycle.
- `afull`  out  1  free entries ≤ `AFULL_TH`; the upstream source must stop issuing.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `ovf`  out  1  sticky overflow flag; tied 0 when the configuration feature is compiled out.

## Operation
- Storage is a `DEPTH` × `DWID` register array with a write pointer and a read pointer, both `$clog2(DEPTH)` bits wide. Pointers wrap modulo `DEPTH` with no special case.
- Push: `in_vld` is high and the FIFO is not full, or `in_vld` is high and it is full while a pop occurs in the same cycle. The word goes to `mem[wr_ptr]` and `wr_ptr` increments.
- Pop: `out_vld && out_rdy`. `rd_ptr` increments.
- Count update: push only gives +1, pop only gives −1, push and pop together give no change.
- Drop: `in_vld` is high, `count == DEPTH`, and there is no pop. The word is discarded, storage and pointers are unchanged, and `ovf` sets (macro-dependent).
- `out_rdy` while `out_vld == 0` is ignored; no underflow is possible.
- Outputs:
  - `out_vld = (count != 0)`.
  - `dout = mem[rd_ptr]`; its value is don't-care when `out_vld == 0`.
  - `afull = ((DEPTH - count) <= AFULL_TH)`.
  - All three derive only from registers. There is no combinational path from `din`, `in_vld` or `out_rdy` to any output.
- Reset, asynchronous on `rst_n` low:
  - Pointers, `count` and `ovf` go to 0.
  - All storage goes to 0, so `dout` reads 0.
  - Therefore `out_vld` = 0 and `afull` = 0.
  - Reset mid-operation discards all contents immediately; writes in flight are lost.
- Ordering is strict FIFO. Every accepted word is popped exactly once, unmodified.

## Timing
- Write-to-output latency is 1 cycle. If `in_vld` is high at edge N into an empty FIFO, `out_vld` = 1 and `dout` = that word after edge N.
- Throughput is one push and one pop per cycle sustained, including at `count == DEPTH` (simultaneous pop frees the slot).
- `afull` updates one cycle after the push/pop that changes `count`. Upstream may legally deliver up to `AFULL_TH` further words after seeing `afull`.
- Deassertion of `rst_n` is asynchronous. Release must be synchronised externally; the block assumes release is clean relative to `clk`.

## Configuration
- Macro `CTRL_DLY_FIFO_OVF_EN`.
- Defined:
  - `ovf` sets on the first drop and stays set until reset.
  - A 16-bit saturating drop counter increments per dropped word. It is readable only in simulation/debug through the hierarchy.
- Undefined: no flag or counter logic is built, `ovf` is constant 0, and drops are silent.
- Push/pop/drop datapath behaviour is identical in both builds.

## Test plan
- Reset: hold `rst_n` = 0, then release with no traffic. Required: `out_vld` = 0, `count` = 0, `afull` = 0, `ovf` = 0, `dout` = 0.
- Basic pass: push 0x001..0x005 on consecutive cycles with `out_rdy` = 1. Required: `dout` shows 0x001..0x005 on consecutive cycles, each one cycle after its push; `count` peaks at 1.
- Fill and afull, with `DEPTH` = 8 and `AFULL_TH` = 2: `out_rdy` = 0, push 8 words. Required: `afull` rises the cycle after the 6th push; `count` = 8 after the 8th push; then drain with `out_rdy` = 1 and all 8 words emerge in order.
- Full with simultaneous push/pop: at `count` = 8, `in_vld` = 1 with `din` = 0x3AA and `out_rdy` = 1 in the same cycle. Required: `count` stays 8, and 0x3AA is the last word drained.
- Overflow: at `count` = 8, `out_rdy` = 0, push 0x155. Required: the word is dropped and `count` stays 8. With `CTRL_DLY_FIFO_OVF_EN`, `ovf` = 1 from the next cycle, stays 1, and the drop counter = 1; without it, `ovf` = 0.
- Wrap and mid-op reset: push and pop 20 random words with random `out_rdy`, then assert `rst_n` = 0 with `count` = 3. Required: the output order matches a scoreboard across the pointer wrap; after reset, `count` = 0 and `out_vld` = 0 immediately, asynchronously.
